apb_master_queue: RTL and testbench

Parametrised APB4 master transactor for DV/emulation benches; successor to the single-transfer APB driver. Accepts queued read/write commands on a valid/ready interface, issues them back-to-back on APB with PSTRB/PPROT and a configurable bus-timeout, and returns ordered responses through a response FIFO. Sits between bench/host command logic and the DUT APB slave port.

---
 rtl/apb_master_queue_if.sv | 54 +++++
 rtl/apb_master_queue.sv | 261 ++++++++++++++++++++++++++
 tb/tb_apb_master_queue.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_queue_if.sv
// Command/response stream and APB4 bus bundle for apb_master_queue.
// The master modport is the transactor side; slave is the bench/host plus APB slave side.
interface apb_master_queue_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [ADDR_WIDTH-1:0]     cmd_addr;
    logic [DATA_WIDTH-1:0]     cmd_wdata;
    logic [DATA_WIDTH/8-1:0]   cmd_strb;
    logic [2:0]                cmd_prot;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_write;
    logic                      rsp_err;
    logic                      rsp_timeout;

    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_WIDTH-1:0]     paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic [2:0]                pprot;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pready;
    logic                      pslverr;

    logic                      busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_write, rsp_err, rsp_timeout,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr,
        output busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_write, rsp_err, rsp_timeout,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr,
        input  busy
    );
endinterface

// File: rtl/apb_master_queue.sv
// APB4 master transactor: queued commands issued back-to-back on APB, with bus timeout
// and in-order responses returned through a first-word fall-through FIFO.
//
//   state     | meaning
//   ST_IDLE   | no transfer on the bus; APB outputs at 0
//   ST_SETUP  | psel=1, penable=0, address phase of the current transfer
//   ST_ACCESS | psel=1, penable=1, waiting for pready or timeout
module apb_master_queue #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int CMD_DEPTH  = 4,
    parameter int RSP_DEPTH  = 4,
    parameter int TIMEOUT    = 100
) (
    input  logic               clk,
    input  logic               reset_n,
    apb_master_queue_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CPW        = $clog2(CMD_DEPTH);
    localparam int RPW        = $clog2(RSP_DEPTH);
    localparam int TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLIM       = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [CPW:0]    CMD_FULL   = (CPW + 1)'(CMD_DEPTH);
    localparam logic [RPW:0]    RSP_FULL   = (RPW + 1)'(RSP_DEPTH);
    localparam logic [RPW:0]    RSP_LAST   = (RPW + 1)'(RSP_DEPTH - 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TLIM);
    localparam logic [TW-1:0]   TIMER_MAX  = '1;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
        logic [2:0]            prot;
    } cmd_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  write;
        logic                  err;
        logic                  timeout;
    } rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t r_state;
    state_t w_state_next;

    cmd_t            r_cmd_mem [CMD_DEPTH];
    logic [CPW-1:0]  r_cmd_wr_ptr;
    logic [CPW-1:0]  r_cmd_rd_ptr;
    logic [CPW:0]    r_cmd_count;
    cmd_t            w_cmd_in;
    cmd_t            w_cmd_head;
    logic            w_cmd_push;
    logic            w_cmd_pop;
    logic            w_cmd_empty;

    rsp_t            r_rsp_mem [RSP_DEPTH];
    logic [RPW-1:0]  r_rsp_wr_ptr;
    logic [RPW-1:0]  r_rsp_rd_ptr;
    logic [RPW:0]    r_rsp_count;
    rsp_t            w_rsp_in;
    rsp_t            w_rsp_head;
    logic            w_rsp_push;
    logic            w_rsp_pop;

    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_WIDTH-1:0] r_pstrb;
    logic [2:0]            r_pprot;

    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_next;
    logic            w_timeout_hit;
    logic            w_apb_load;
    logic            w_apb_clear;

    // ---------------- command FIFO ----------------
    assign w_cmd_in      = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata,
                             strb: bus.cmd_strb, prot: bus.cmd_prot};
    assign bus.cmd_ready = (r_cmd_count != CMD_FULL);
    assign w_cmd_push    = bus.cmd_valid && bus.cmd_ready;
    assign w_cmd_empty   = (r_cmd_count == '0);
    assign w_cmd_head    = r_cmd_mem[r_cmd_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_cmd_push) begin
            r_cmd_mem[r_cmd_wr_ptr] <= w_cmd_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_wr_ptr <= '0;
            r_cmd_rd_ptr <= '0;
            r_cmd_count  <= '0;
        end else begin
            if (w_cmd_push) begin
                r_cmd_wr_ptr <= r_cmd_wr_ptr + 1'b1;
            end
            if (w_cmd_pop) begin
                r_cmd_rd_ptr <= r_cmd_rd_ptr + 1'b1;
            end
            case ({w_cmd_push, w_cmd_pop})
                2'b10:   r_cmd_count <= r_cmd_count + 1'b1;
                2'b01:   r_cmd_count <= r_cmd_count - 1'b1;
                default: r_cmd_count <= r_cmd_count;
            endcase
        end
    end

    // ---------------- response FIFO (first-word fall-through) ----------------
    assign w_rsp_head      = r_rsp_mem[r_rsp_rd_ptr];
    assign bus.rsp_valid   = (r_rsp_count != '0);
    assign bus.rsp_rdata   = w_rsp_head.rdata;
    assign bus.rsp_write   = w_rsp_head.write;
    assign bus.rsp_err     = w_rsp_head.err;
    assign bus.rsp_timeout = w_rsp_head.timeout;
    assign w_rsp_pop       = bus.rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (w_rsp_push) begin
            r_rsp_mem[r_rsp_wr_ptr] <= w_rsp_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_wr_ptr <= '0;
            r_rsp_rd_ptr <= '0;
            r_rsp_count  <= '0;
        end else begin
            if (w_rsp_push) begin
                r_rsp_wr_ptr <= r_rsp_wr_ptr + 1'b1;
            end
            if (w_rsp_pop) begin
                r_rsp_rd_ptr <= r_rsp_rd_ptr + 1'b1;
            end
            case ({w_rsp_push, w_rsp_pop})
                2'b10:   r_rsp_count <= r_rsp_count + 1'b1;
                2'b01:   r_rsp_count <= r_rsp_count - 1'b1;
                default: r_rsp_count <= r_rsp_count;
            endcase
        end
    end

    // ---------------- transfer FSM ----------------
    assign w_timeout_hit = (TIMEOUT != 0) && (r_timer == TIMER_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
        end
    end

    // A new transfer needs a free response slot counting the one in flight; when chaining
    // out of ACCESS the finishing transfer still occupies its slot, hence RSP_LAST there.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_cmd_pop    = 1'b0;
        w_rsp_push   = 1'b0;
        w_rsp_in     = '0;
        w_apb_load   = 1'b0;
        w_apb_clear  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timer_next = '0;
                if (!w_cmd_empty && (r_rsp_count < RSP_FULL)) begin
                    w_cmd_pop    = 1'b1;
                    w_apb_load   = 1'b1;
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_timer_next = '0;
                w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.pready || w_timeout_hit) begin
                    w_rsp_push       = 1'b1;
                    w_rsp_in.write   = r_pwrite;
                    w_rsp_in.rdata   = (bus.pready && !r_pwrite) ? bus.prdata : '0;
                    w_rsp_in.err     = bus.pready ? bus.pslverr : 1'b1;
                    w_rsp_in.timeout = !bus.pready;
                    w_timer_next     = '0;
                    if (!w_cmd_empty && (r_rsp_count < RSP_LAST)) begin
                        w_cmd_pop    = 1'b1;
                        w_apb_load   = 1'b1;
                        w_state_next = ST_SETUP;
                    end else begin
                        w_apb_clear  = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end else if (r_timer != TIMER_MAX) begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            default: begin
                w_apb_clear  = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- APB output registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_pprot   <= '0;
        end else if (w_apb_load) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= w_cmd_head.write;
            r_paddr   <= w_cmd_head.addr;
            r_pprot   <= w_cmd_head.prot;
            r_pwdata  <= w_cmd_head.write ? w_cmd_head.wdata : '0;
            r_pstrb   <= w_cmd_head.write ? w_cmd_head.strb : '0;
        end else if (w_apb_clear) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_pprot   <= '0;
        end else if (r_state == ST_SETUP) begin
            r_penable <= 1'b1;
        end
    end

    assign bus.psel    = r_psel;
    assign bus.penable = r_penable;
    assign bus.pwrite  = r_pwrite;
    assign bus.paddr   = r_paddr;
    assign bus.pwdata  = r_pwdata;
    assign bus.pstrb   = r_pstrb;
    assign bus.pprot   = r_pprot;

    assign bus.busy    = (r_state != ST_IDLE) || !w_cmd_empty;

endmodule

// File: tb/tb_apb_master_queue.sv
// Self-checking bench for apb_master_queue: randomized APB slave and response consumer
// against a transaction-level model of expected bus transfers and responses.
module tb_apb_master_queue;
    localparam int AW        = 20;
    localparam int DW        = 32;
    localparam int SW        = DW / 8;
    localparam int CMD_DEPTH = 4;
    localparam int RSP_DEPTH = 4;
    localparam int TIMEOUT   = 100;
    localparam int NEVER     = 1000000;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    apb_master_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_queue #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CMD_DEPTH (CMD_DEPTH),
        .RSP_DEPTH (RSP_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected APB setup fields {pwrite,paddr,pwdata,pstrb,pprot} and responses {rdata,write,err,timeout}
    logic [59:0] cmd_q[$];
    logic [34:0] exp_q[$];

    int          slv_wait      = -1;
    int          slv_err_mode  = 0;
    int          slv_to_pct    = 0;
    logic        slv_fix_rdata = 1'b0;
    logic [31:0] slv_rdata     = '0;
    int          rsp_mode      = 0;

    int          xfers       = 0;
    int          psel_cycles = 0;
    int          pen_cycles  = 0;
    int          run         = 0;
    int          max_run     = 0;
    int          last_len    = 0;
    int          rsp_seen    = 0;
    logic [34:0] last_rsp    = '0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        xfers       = 0;
        psel_cycles = 0;
        pen_cycles  = 0;
        run         = 0;
        max_run     = 0;
        last_len    = 0;
        rsp_seen    = 0;
    endtask

    // APB slave + transfer monitor; decides wait states and error, records the expected response.
    initial begin : apb_slave
        int          k      = 0;
        int          wait_n = 0;
        logic        err    = 1'b0;
        logic        wr     = 1'b0;
        logic [31:0] rd     = '0;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                bus.pready = 1'b0;
                run        = 0;
            end else if (bus.psel && !bus.penable) begin
                xfers++;
                psel_cycles++;
                run++;
                if (run > max_run) max_run = run;
                if (cmd_q.size() == 0) begin
                    check_eq("apb_unexpected_setup", 64'(1), 64'(0));
                end else begin
                    check_eq("apb_setup",
                             64'({bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb, bus.pprot}),
                             64'(cmd_q.pop_front()));
                end
                wr     = bus.pwrite;
                k      = 0;
                wait_n = (slv_wait >= 0) ? slv_wait : int'($urandom_range(0, 3));
                if (slv_to_pct > 0 && int'($urandom_range(0, 99)) < slv_to_pct) wait_n = NEVER;
                err = (slv_err_mode == 1) ? 1'b1 :
                      (slv_err_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
                rd  = slv_fix_rdata ? slv_rdata : $urandom;
                bus.pready  = 1'($urandom_range(0, 1));
                bus.pslverr = 1'($urandom_range(0, 1));
            end else if (bus.psel && bus.penable) begin
                psel_cycles++;
                pen_cycles++;
                run++;
                if (run > max_run) max_run = run;
                if (k == wait_n) begin
                    bus.pready  = 1'b1;
                    bus.pslverr = err;
                    bus.prdata  = rd;
                    exp_q.push_back({wr ? 32'h0 : rd, wr, err, 1'b0});
                    last_len = k + 1;
                end else begin
                    bus.pready  = 1'b0;
                    bus.pslverr = 1'($urandom_range(0, 1));
                    bus.prdata  = $urandom;
                    if (k == TIMEOUT - 1) begin
                        exp_q.push_back({32'h0, wr, 1'b1, 1'b1});
                        last_len = TIMEOUT;
                    end
                    if (k == TIMEOUT) check_eq("access_len_overrun", 64'(k + 1), 64'(TIMEOUT));
                end
                k++;
            end else begin
                run         = 0;
                bus.pready  = 1'($urandom_range(0, 1));
                bus.pslverr = 1'($urandom_range(0, 1));
            end
        end
    end

    // Response consumer: applies rsp_ready policy and compares each popped response in order.
    initial begin : rsp_consumer
        logic [34:0] e;
        bus.rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                case (rsp_mode)
                    0:       bus.rsp_ready = 1'b1;
                    1:       bus.rsp_ready = 1'($urandom_range(0, 1));
                    default: bus.rsp_ready = 1'b0;
                endcase
                if (bus.rsp_valid && bus.rsp_ready) begin
                    last_rsp = {bus.rsp_rdata, bus.rsp_write, bus.rsp_err, bus.rsp_timeout};
                    rsp_seen++;
                    if (exp_q.size() == 0) begin
                        check_eq("rsp_unexpected", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("rsp", 64'(last_rsp), 64'(e));
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input logic [2:0] p);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_strb  = s;
        bus.cmd_prot  = p;
        while (!bus.cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            check_eq("cmd_accept_timeout", 64'(0), 64'(1));
        end else begin
            cmd_q.push_back({w, a, w ? d : 32'h0, w ? s : 4'h0, p});
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((bus.busy || bus.rsp_valid || bus.psel || exp_q.size() != 0 || cmd_q.size() != 0)
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 64'(n < 3000), 64'(1));
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int cnt;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.cmd_prot  = '0;
        reset_n       = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("reset_apb", 64'({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
                                   bus.pstrb, bus.pprot}), 64'(0));
        check_eq("reset_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        check_eq("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check_eq("reset_busy", 64'(bus.busy), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // single write, zero wait states
        clear_stats();
        slv_wait = 0;
        send_cmd(1'b1, 20'h00010, 32'hDEADBEEF, 4'hF, 3'b000);
        check_eq("latency_e0_psel", 64'(bus.psel), 64'(0));
        @(negedge clk);
        check_eq("latency_e1_psel", 64'(bus.psel), 64'(1));
        wait_drain("drain_single_write");
        check_eq("wr_psel_cycles", 64'(psel_cycles), 64'(2));
        check_eq("wr_penable_cycles", 64'(pen_cycles), 64'(1));
        check_eq("wr_rsp_count", 64'(rsp_seen), 64'(1));
        check_eq("wr_rsp_fields", 64'(last_rsp), 64'({32'h0, 1'b1, 1'b0, 1'b0}));

        // read with three wait states
        clear_stats();
        slv_wait      = 3;
        slv_fix_rdata = 1'b1;
        slv_rdata     = 32'h12345678;
        send_cmd(1'b0, 20'h00020, 32'($urandom), 4'($urandom), 3'b010);
        wait_drain("drain_read");
        check_eq("rd_access_cycles", 64'(pen_cycles), 64'(4));
        check_eq("rd_rsp_fields", 64'(last_rsp), 64'({32'h12345678, 1'b0, 1'b0, 1'b0}));
        slv_fix_rdata = 1'b0;

        // four queued writes back-to-back
        clear_stats();
        slv_wait = 0;
        for (int i = 0; i < 4; i++) begin
            send_cmd(1'b1, 20'(20'h00100 + i * 4), 32'($urandom), 4'hF, 3'($urandom));
        end
        wait_drain("drain_four_writes");
        check_eq("b2b_psel_run", 64'(max_run), 64'(8));
        check_eq("b2b_transfers", 64'(xfers), 64'(4));
        check_eq("b2b_penable_cycles", 64'(pen_cycles), 64'(4));
        check_eq("b2b_rsp_count", 64'(rsp_seen), 64'(4));

        // slave error on a write
        clear_stats();
        slv_wait     = -1;
        slv_err_mode = 1;
        send_cmd(1'b1, 20'h00404, 32'($urandom), 4'h3, 3'b001);
        wait_drain("drain_slverr");
        check_eq("slverr_err_to", 64'(last_rsp[1:0]), 64'(2'b10));
        slv_err_mode = 0;

        // timeout: pready never asserted
        clear_stats();
        slv_wait = NEVER;
        send_cmd(1'b0, 20'h00808, 32'h0, 4'h0, 3'b000);
        n = 0;
        while (!bus.penable && n < 50) begin
            @(negedge clk);
            n++;
        end
        cnt = 0;
        while (bus.penable && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("to_access_cycles", 64'(cnt), 64'(TIMEOUT));
        check_eq("to_idle_psel", 64'(bus.psel), 64'(0));
        wait_drain("drain_timeout");
        check_eq("to_rsp_fields", 64'(last_rsp), 64'({32'h0, 1'b0, 1'b1, 1'b1}));
        check_eq("to_last_len", 64'(last_len), 64'(TIMEOUT));

        // response backpressure: only RSP_DEPTH transfers may complete
        clear_stats();
        slv_wait = -1;
        rsp_mode = 2;
        for (int i = 0; i < 6; i++) begin
            send_cmd(1'b0, 20'($urandom), 32'($urandom), 4'($urandom), 3'($urandom));
        end
        repeat (40) @(negedge clk);
        check_eq("bp_transfers_stalled", 64'(xfers), 64'(RSP_DEPTH));
        check_eq("bp_psel_low", 64'(bus.psel), 64'(0));
        check_eq("bp_busy", 64'(bus.busy), 64'(1));
        check_eq("bp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        rsp_mode = 0;
        wait_drain("drain_backpressure");
        check_eq("bp_transfers_total", 64'(xfers), 64'(6));
        check_eq("bp_rsp_count", 64'(rsp_seen), 64'(6));

        // reset asserted in the middle of ACCESS with another command queued
        slv_wait = NEVER;
        send_cmd(1'b0, 20'h00C00, 32'h0, 4'h0, 3'b000);
        send_cmd(1'b1, 20'h00C04, 32'hCAFEF00D, 4'hF, 3'b000);
        repeat (5) @(negedge clk);
        check_eq("rst_pre_access", 64'(bus.penable), 64'(1));
        reset_n = 1'b0;
        #1;
        check_eq("rst_psel", 64'({bus.psel, bus.penable}), 64'(0));
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check_eq("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        check_eq("rst_busy", 64'(bus.busy), 64'(0));
        @(negedge clk);
        cmd_q.delete();
        exp_q.delete();
        clear_stats();
        slv_wait = -1;
        reset_n  = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("rst_no_response", 64'(bus.rsp_valid), 64'(0));
        check_eq("rst_no_transfer", 64'(xfers), 64'(0));

        // randomized traffic
        clear_stats();
        slv_wait     = -1;
        slv_err_mode = 2;
        slv_to_pct   = 3;
        rsp_mode     = 1;
        for (int i = 0; i < 250; i++) begin
            send_cmd(1'($urandom_range(0, 1)), 20'($urandom), 32'($urandom), 4'($urandom),
                     3'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain("drain_random");
        check_eq("rand_transfers", 64'(xfers), 64'(250));
        check_eq("rand_rsp_count", 64'(rsp_seen), 64'(250));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
